rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_if.sv | 20 ++
 rtl/rom_loader.sv | 123 ++++++++++++
 tb/tb_rom_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Source byte stream and ROM programming bus shared by the loader and its environment.
// The master side is the loader: it accepts source bytes and drives the ROM write port.
interface rom_loader_if;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       prog;
  logic [15:0] prog_ab;
  logic [7:0] prog_do;

  modport master (
    input  src_valid, src_data,
    output src_ready, prog, prog_ab, prog_do
  );

  modport slave (
    output src_valid, src_data,
    input  src_ready, prog, prog_ab, prog_do
  );
endinterface

// File: rtl/rom_loader.sv
// Streams an iNES-style image into ROM: validates the 16-byte header, writes every
// accepted byte at its index, and holds the cores in reset until the image is complete.
module rom_loader #(
  parameter int unsigned IMG_BYTES = 24592,
  parameter int unsigned TIMEOUT   = 1048576
) (
  input  logic               ppu_clk,
  input  logic               rst,
  input  logic               start,
  rom_loader_if.master       bus,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);

  localparam int unsigned  TW    = $clog2(TIMEOUT + 1);
  localparam logic [15:0]  LAST  = 16'(IMG_BYTES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, FLUSH, DONE, ERR} state_t;

  state_t        state, state_n;
  logic [15:0]   idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [15:0]   ab_q, ab_n;
  logic [7:0]    do_q, do_n;
  logic [1:0]    err_q, err_n;
  logic [1:0]    hdr_err;
  logic          accept;

  assign bus.src_ready = (state == HDR) || (state == LOAD);
  assign bus.prog      = (state == HDR) || (state == LOAD) || (state == FLUSH);
  assign bus.prog_ab   = ab_q;
  assign bus.prog_do   = do_q;
  assign busy          = bus.prog;
  assign done          = (state == DONE);
  assign cpu_rst       = (state != DONE);
  assign err           = err_q;
  assign accept        = bus.src_valid && bus.src_ready;

  // Magic bytes report code 1; format bytes (mapper/version fields) report code 2.
  always_comb begin
    hdr_err = '0;
    case (idx)
      16'd0: if (bus.src_data != 8'h4E) hdr_err = 2'd1;
      16'd1: if (bus.src_data != 8'h45) hdr_err = 2'd1;
      16'd2: if (bus.src_data != 8'h53) hdr_err = 2'd1;
      16'd3: if (bus.src_data != 8'h1A) hdr_err = 2'd1;
      16'd4: if (bus.src_data != 8'h01) hdr_err = 2'd2;
      16'd5: if (bus.src_data != 8'h01) hdr_err = 2'd2;
      16'd6: if (bus.src_data[7:4] != 4'h0) hdr_err = 2'd2;
      16'd7: if (bus.src_data[7:4] != 4'h0) hdr_err = 2'd2;
      default: hdr_err = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    ab_n    = ab_q;
    do_n    = do_q;
    err_n   = err_q;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = HDR;
          idx_n   = '0;
          tcnt_n  = '0;
          ab_n    = '0;
          do_n    = '0;
          err_n   = '0;
        end
      end
      HDR, LOAD: begin
        // An accept on the timeout edge takes priority and restarts the idle count.
        if (accept) begin
          ab_n   = idx;
          do_n   = bus.src_data;
          idx_n  = idx + 16'd1;
          tcnt_n = '0;
          if (state == HDR) begin
            if (hdr_err != 2'd0) begin
              state_n = ERR;
              err_n   = hdr_err;
            end else if (idx == 16'd15) begin
              state_n = LOAD;
            end
          end else if (idx == LAST) begin
            state_n = FLUSH;
          end
        end else if (tcnt == TLAST) begin
          state_n = ERR;
          err_n   = 2'd3;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      FLUSH:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ppu_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      tcnt  <= '0;
      ab_q  <= '0;
      do_q  <= '0;
      err_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      tcnt  <= tcnt_n;
      ab_q  <= ab_n;
      do_q  <= do_n;
      err_q <= err_n;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a 48-byte image and an 8-cycle idle timeout.
module tb_rom_loader;

  logic       ppu_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_rst;
  logic       busy;
  logic       done;
  logic [1:0] err;

  rom_loader_if bus ();

  rom_loader #(.IMG_BYTES(48), .TIMEOUT(8)) dut (
    .ppu_clk (ppu_clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.master),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 ppu_clk = ~ppu_clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned gen   = 0;
  logic [7:0]  img     [0:47];
  logic [7:0]  mem     [0:255];
  int unsigned mem_gen [0:255];

  // Behavioural ROM: captures every write the loader issues, tagged with the load number.
  always @(posedge ppu_clk) begin
    if (bus.prog === 1'b1) begin
      mem[bus.prog_ab[7:0]]     <= bus.prog_do;
      mem_gen[bus.prog_ab[7:0]] <= gen;
    end
  end

  task automatic tick;
    @(posedge ppu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start;
    gen++;
    start = 1'b1;
    bus.src_valid = 1'b0;
    tick;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);
  endtask

  task automatic send(input logic [7:0] d, input int k);
    bus.src_valid = 1'b1;
    bus.src_data  = d;
    tick;
    bus.src_valid = 1'b0;
    check($sformatf("ab_%0d", k), bus.prog_ab, k);
    check($sformatf("do_%0d", k), bus.prog_do, d);
  endtask

  task automatic check_flush_done;
    check("flush_prog", bus.prog, 1);
    check("flush_done", done, 0);
    check("flush_cpu_rst", cpu_rst, 1);
    check("flush_last_do", bus.prog_do, img[47]);
    tick;
    check("done_done", done, 1);
    check("done_cpu_rst", cpu_rst, 0);
    check("done_busy", busy, 0);
    check("done_prog", bus.prog, 0);
    check("done_ready", bus.src_ready, 0);
  endtask

  task automatic check_rom;
    int unsigned bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (a < 48) begin
        if (mem_gen[a] != gen || mem[a] !== img[a]) bad++;
      end else if (mem_gen[a] == gen) begin
        bad++;
      end
    end
    check("rom_contents", bad, 0);
  endtask

  // Whole image; with gaps, idle cycles and stray start pulses are sprinkled in.
  task automatic load_image(input bit gaps);
    int unsigned n;
    gen++;
    start = 1'b1;
    bus.src_valid = !gaps;
    bus.src_data  = img[0];
    tick;
    start = 1'b0;
    check("load_hdr_busy", busy, 1);
    check("load_hdr_ab", bus.prog_ab, 0);
    for (int k = 0; k < 48; k++) begin
      if (gaps) begin
        n = $urandom_range(0, 6);
        repeat (n) begin
          bus.src_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          tick;
          check("gap_busy", busy, 1);
        end
        start = 1'b0;
      end
      bus.src_valid = 1'b1;
      bus.src_data  = img[k];
      tick;
      check($sformatf("load_ab_%0d", k), bus.prog_ab, k);
      check($sformatf("load_do_%0d", k), bus.prog_do, img[k]);
    end
    bus.src_valid = 1'b0;
    check_flush_done;
    check_rom;
  endtask

  initial begin
    for (int k = 0; k < 48; k++) img[k] = 8'h00;
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
    img[4] = 8'h01; img[5] = 8'h01;
    for (int k = 16; k < 48; k++) img[k] = 8'(8'h10 + k - 16);
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'h00;
      mem_gen[a] = 0;
    end

    rst = 1'b0;
    start = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data  = 8'h00;
    #1;
    check("rst_prog", bus.prog, 0);
    check("rst_ab", bus.prog_ab, 0);
    check("rst_do", bus.prog_do, 0);
    check("rst_ready", bus.src_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    check("idle_ready", bus.src_ready, 0);

    // Full image with src_valid held high: done lands on the 50th edge after start.
    load_image(1'b0);

    // Bad magic on byte 2.
    do_start;
    send(img[0], 0);
    send(img[1], 1);
    send(8'h54, 2);
    check("magic_err", err, 1);
    check("magic_prog", bus.prog, 0);
    check("magic_ready", bus.src_ready, 0);
    check("magic_busy", busy, 0);
    check("magic_done", done, 0);
    check("magic_cpu_rst", cpu_rst, 1);
    bus.src_valid = 1'b1;
    tick;
    bus.src_valid = 1'b0;
    check("magic_err_hold", err, 1);
    check("magic_ab_hold", bus.prog_ab, 2);

    // Unsupported version byte.
    do_start;
    for (int k = 0; k < 4; k++) send(img[k], k);
    check("fmt4_pre_busy", busy, 1);
    send(8'h02, 4);
    check("fmt4_err", err, 2);
    check("fmt4_busy", busy, 0);

    // Mapper 1 in byte 6.
    do_start;
    for (int k = 0; k < 6; k++) send(img[k], k);
    send(8'h10, 6);
    check("fmt6_err", err, 2);
    check("fmt6_prog", bus.prog, 0);

    // Stall after byte 20: error exactly on the 8th idle edge.
    do_start;
    for (int k = 0; k <= 20; k++) send(img[k], k);
    repeat (7) tick;
    check("to_pre_busy", busy, 1);
    check("to_pre_err", err, 0);
    tick;
    check("to_err", err, 3);
    check("to_busy", busy, 0);
    check("to_ready", bus.src_ready, 0);
    check("to_cpu_rst", cpu_rst, 1);

    // A byte landing on the 8th idle edge keeps the load alive.
    do_start;
    for (int k = 0; k <= 20; k++) send(img[k], k);
    repeat (7) tick;
    send(img[21], 21);
    check("to_race_busy", busy, 1);
    check("to_race_err", err, 0);
    repeat (7) tick;
    check("to_race_still_busy", busy, 1);
    for (int k = 22; k < 48; k++) send(img[k], k);
    check_flush_done;
    check_rom;

    // Asynchronous reset between edges mid-LOAD.
    do_start;
    for (int k = 0; k <= 30; k++) send(img[k], k);
    #3;
    rst = 1'b0;
    #1;
    check("arst_prog", bus.prog, 0);
    check("arst_ab", bus.prog_ab, 0);
    check("arst_do", bus.prog_do, 0);
    check("arst_ready", bus.src_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_cpu_rst", cpu_rst, 1);
    tick;
    rst = 1'b1;
    tick;
    check("arst_idle_busy", busy, 0);
    load_image(1'b0);

    // Random gaps and stray starts; header filler bytes and byte6 low nibble set.
    for (int k = 8; k < 16; k++) img[k] = 8'hA5;
    img[6] = 8'h0F;
    img[7] = 8'h0E;
    load_image(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
